led_pattern_ctrl: RTL and testbench

- Parametrised LED pattern engine for the board LED bank; successor to the single-rate blink controller.
- Advances an LED_W-wide pattern on an internal tick derived from `clk`; the tick rate is selected from four power-of-two rates by `speed`.
- Supports four display modes, an enable/freeze input and a per-step strobe.
- Sits between the board-level switch inputs and the LED pins; creates no derived clocks.

---
 rtl/led_pkg.sv | 16 +
 rtl/led_tick_gen.sv | 36 +++
 rtl/led_pattern_ctrl.sv | 98 +++++++++
 tb/tb_led_pattern_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants for the LED pattern engine: display modes and sweep direction.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK    = 2'b00,
        MODE_ROTATE   = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_FILL     = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage : led_pkg

// File: rtl/led_tick_gen.sv
// Free-running divider producing a one-cycle tick every 2^(DIV_BASE + speed*DIV_STEP) cycles.
// The counter is never cleared, so a speed change takes effect on the next match.
module led_tick_gen #(
    parameter int DIV_BASE = 24,
    parameter int DIV_STEP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int CW = DIV_BASE + 3 * DIV_STEP;
    localparam int KW = $clog2(CW + 1);

    logic [CW-1:0] cnt;
    logic [KW-1:0] k;
    logic [CW-1:0] mask;

    // Tick whenever the low k counter bits are all ones; k = CW shifts the mask to all ones.
    always_comb begin
        k    = KW'(DIV_BASE + int'(speed) * DIV_STEP);
        mask = ~({CW{1'b1}} << k);
        tick = &(cnt | ~mask);
    end

    // Divider counts every cycle, independent of enable or mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule : led_tick_gen

// File: rtl/led_pattern_ctrl.sv
// LED pattern engine: blink, rotate, ping-pong and fill-bar patterns advanced on a divided tick.
// A mode change reseeds the pattern and takes priority over an advance in the same cycle.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int LED_W    = 16,
    parameter int DIV_BASE = 24,
    parameter int DIV_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       speed,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic             step
);

    localparam logic [LED_W-1:0] ONE_HOT0 = {{(LED_W-1){1'b0}}, 1'b1};

    mode_e            mode_q;
    dir_e             dir;
    logic             tick;
    logic             reload;
    logic             advance;
    logic [LED_W-1:0] led_nxt;
    logic [LED_W-1:0] seed;
    dir_e             dir_nxt;

    led_tick_gen #(
        .DIV_BASE (DIV_BASE),
        .DIV_STEP (DIV_STEP)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .speed (speed),
        .tick  (tick)
    );

    // Seed for the incoming mode and the next pattern value for the current mode.
    always_comb begin
        reload  = (mode_e'(mode) != mode_q);
        advance = tick & en & ~reload;

        case (mode_e'(mode))
            MODE_BLINK:    seed = '1;
            MODE_ROTATE:   seed = ONE_HOT0;
            MODE_PINGPONG: seed = ONE_HOT0;
            default:       seed = '0;
        endcase

        led_nxt = led;
        dir_nxt = dir;
        case (mode_q)
            MODE_BLINK: led_nxt = ~led;
            MODE_ROTATE: led_nxt = {led[LED_W-2:0], led[LED_W-1]};
            MODE_PINGPONG: begin
                if (dir == DIR_LEFT && led[LED_W-1]) begin
                    dir_nxt = DIR_RIGHT;
                    led_nxt = led >> 1;
                end else if (dir == DIR_RIGHT && led[0]) begin
                    dir_nxt = DIR_LEFT;
                    led_nxt = led << 1;
                end else if (dir == DIR_LEFT) begin
                    led_nxt = led << 1;
                end else begin
                    led_nxt = led >> 1;
                end
            end
            default: begin
                if (&led) led_nxt = '0;
                else      led_nxt = {led[LED_W-2:0], 1'b1};
            end
        endcase
    end

    // Pattern state: reload beats advance, advance beats hold; step marks each advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led    <= '1;
            step   <= 1'b0;
            mode_q <= MODE_BLINK;
            dir    <= DIR_LEFT;
        end else begin
            mode_q <= mode_e'(mode);
            step   <= 1'b0;
            if (reload) begin
                led <= seed;
                dir <= DIR_LEFT;
            end else if (advance) begin
                led  <= led_nxt;
                dir  <= dir_nxt;
                step <= 1'b1;
            end
        end
    end

endmodule : led_pattern_ctrl

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl with LED_W=8, DIV_BASE=2, DIV_STEP=1.
module tb_led_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [1:0] speed = 2'd0;
    logic [1:0] mode = 2'd0;
    logic [7:0] led;
    logic       step;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         rel = 0;
    logic [7:0] exp_q[$];

    led_pattern_ctrl #(.LED_W(8), .DIV_BASE(2), .DIV_STEP(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .speed (speed),
        .mode  (mode),
        .led   (led),
        .step  (step)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic wait_step(output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    // Pops n expected values, each matched to a step; intervals after the first must equal period.
    // first_at >= 0 also checks the first step's cycle relative to rel.
    task automatic check_steps(input string name, input int n, input int period, input int first_at);
        bit ok;
        int at;
        int prev;
        logic [7:0] e;
        prev = 0;
        for (int i = 0; i < n; i++) begin
            wait_step(ok, at);
            e = exp_q.pop_front();
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL %s step %0d timeout: no step seen, expected led %h", name, i, e);
                return;
            end
            if (led !== e) begin
                fails++;
                $display("FAIL %s step %0d led: got %h expected %h", name, i, led, e);
            end
            if (i == 0 && first_at >= 0) begin
                tests++;
                if (at - rel !== first_at) begin
                    fails++;
                    $display("FAIL %s first step cycle: got %0d expected %0d", name, at - rel, first_at);
                end
            end
            if (i > 0) begin
                tests++;
                if (at - prev !== period) begin
                    fails++;
                    $display("FAIL %s step %0d interval: got %0d expected %0d", name, i, at - prev, period);
                end
            end
            prev = at;
        end
    endtask

    task automatic check_now(input string name, input logic [7:0] exp_led, input logic exp_step);
        tests++;
        if (led !== exp_led || step !== exp_step) begin
            fails++;
            $display("FAIL %s: got led %h step %b expected led %h step %b", name, led, step, exp_led, exp_step);
        end
    endtask

    task automatic change_mode(input string name, input logic [1:0] m, input logic [7:0] seed);
        @(negedge clk);
        mode = m;
        @(negedge clk);
        check_now(name, seed, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        speed = 2'd0;
        mode = 2'd0;
        repeat (3) @(negedge clk);
        check_now("reset_state", 8'hFF, 1'b0);
        rst_n = 1'b1;
        rel = cyc;
    endtask

    task automatic test_blink_rate();
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        check_steps("blink_s0", 4, 4, 4);
        speed = 2'd3;
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        check_steps("blink_s3", 3, 32, -1);
        @(negedge clk);
        speed = 2'd0;
    endtask

    task automatic test_rotate();
        logic [7:0] v;
        change_mode("rotate_seed", 2'b01, 8'h01);
        v = 8'h01;
        for (int i = 0; i < 8; i++) begin
            v = {v[6:0], v[7]};
            exp_q.push_back(v);
        end
        check_steps("rotate", 8, 4, -1);
    endtask

    task automatic test_pingpong();
        logic [7:0] seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        change_mode("pingpong_seed", 2'b10, 8'h01);
        for (int i = 0; i < 15; i++) exp_q.push_back(seq[i]);
        check_steps("pingpong", 15, 4, -1);
    endtask

    task automatic test_fill();
        logic [7:0] seq [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                 8'hFF, 8'h00, 8'h01};
        change_mode("fill_seed", 2'b11, 8'h00);
        for (int i = 0; i < 10; i++) exp_q.push_back(seq[i]);
        check_steps("fill", 10, 4, -1);
    endtask

    // Entered right after the fill step to 0x01.
    task automatic test_freeze();
        int bad;
        int t0;
        bad = 0;
        en = 1'b0;
        t0 = cyc;
        repeat (12) begin
            @(negedge clk);
            if (led !== 8'h01 || step !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL freeze_hold: got %0d cycles with led/step changed expected 0", bad);
        end
        en = 1'b1;
        rel = t0;
        exp_q.push_back(8'h03);
        check_steps("freeze_resume", 1, 4, 16);
    endtask

    // Mode change lands on the same edge as a raw tick.
    task automatic test_collision();
        repeat (3) @(negedge clk);
        mode = 2'b01;
        @(negedge clk);
        check_now("collision_reload", 8'h01, 1'b0);
        rel = cyc;
        exp_q.push_back(8'h02);
        check_steps("collision_after", 1, 4, 4);
    endtask

    task automatic test_async_reset();
        change_mode("ar_pp_seed", 2'b10, 8'h01);
        exp_q.push_back(8'h02); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
        check_steps("ar_pre", 3, 4, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("ar_immediate", 8'hFF, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        @(negedge clk);
        check_now("ar_reload_seed", 8'h01, 1'b0);
        exp_q.push_back(8'h02); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
        check_steps("ar_post", 3, 4, 4);
    endtask

    initial begin
        test_reset();
        test_blink_rate();
        test_rotate();
        test_pingpong();
        test_fill();
        test_freeze();
        test_collision();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_led_pattern_ctrl
